mux_nx1_stream: RTL and testbench

Parametrised N-to-1 streaming channel multiplexer, successor to the combinational 4x1 mux. Selects one of `CHANNELS` valid/ready input streams of `WIDTH` bits, either by fixed select or by round-robin arbitration. It forwards the selected stream through a one-entry registered output stage. With packet lock compiled in, a grant is held until the end-of-packet beat.

---
 rtl/mux_nx1_stream_if.sv | 52 +++++
 rtl/mux_nx1_stream.sv | 190 +++++++++++++++++++
 tb/tb_mux_nx1_stream.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_nx1_stream_if.sv
// mux_nx1_stream_if
// -----------------
// Bundle of the mux's control, input-stream and output-stream signals.
//
// Parameters:
//   WIDTH    data width per channel
//   CHANNELS number of input channels
//
// Signals:
//   mode      0 = fixed select, 1 = round-robin
//   sel       channel index used in fixed mode
//   in_data   channel k at [k*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_last   per-channel end-of-packet flag
//   in_ready  per-channel ready (driven by the mux, at most one bit high)
//   out_data  registered output data
//   out_chan  channel that produced out_data
//   out_last  registered copy of the accepted beat's in_last
//   out_valid output register holds a beat
//   out_ready downstream accepts the beat
//
// Modports:
//   slave  - the mux itself
//   master - the environment driving the inputs and consuming the output
interface mux_nx1_stream_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_last;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_chan, out_last, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_chan, out_last, out_valid
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream
// --------------
// N-to-1 valid/ready stream multiplexer. One of CHANNELS input streams is
// chosen either by a fixed select or by round-robin arbitration and is
// forwarded through a one-entry registered output stage (full throughput,
// drain and load on the same edge).
//
// Optional feature (compile-time macro MUX_NX1_PKT_LOCK_EN):
//   defined   - an ARB/LOCK FSM holds the grant on one channel from the first
//               beat of a packet until its in_last beat.
//   undefined - arbitration is re-evaluated on every beat; in_last is only
//               copied through to out_last.
//
// Parameters:
//   WIDTH    data width per channel (default 8)
//   CHANNELS number of input channels, >= 2 (default 4)
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  mux_nx1_stream_if.slave: mode/sel, input streams, output stream
module mux_nx1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux_nx1_stream_if.slave  bus
);
  localparam int               SEL_W    = $clog2(CHANNELS);
  localparam logic [SEL_W:0]   CHAN_CNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  // Output stage and arbitration state
  logic             out_valid_reg;
  logic             out_last_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_chan_reg;
  logic [SEL_W-1:0] ptr_reg;

`ifdef MUX_NX1_PKT_LOCK_EN
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_reg;
  logic [SEL_W-1:0] lock_chan_reg;
`endif

  // Combinational selection
  logic                load_en;
  logic                rr_found;
  logic [SEL_W-1:0]    rr_cand;
  logic                arb_has;
  logic [SEL_W-1:0]    arb_cand;
  logic                has_cand;
  logic [SEL_W-1:0]    cand;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    masked_data [CHANNELS];
  logic [WIDTH-1:0]    cand_data;
  logic                cand_last;
  logic                accept;
  logic [SEL_W-1:0]    ptr_next;

  assign load_en = !out_valid_reg || bus.out_ready;

  // Round-robin search: first valid channel at or after ptr, wrapping at
  // CHANNELS (which need not be a power of two, hence the explicit wrap).
  always_comb begin
    logic [SEL_W:0] idx;
    rr_found = 1'b0;
    rr_cand  = '0;
    idx      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, ptr_reg} + (SEL_W+1)'(i);
      if (idx >= CHAN_CNT) begin
        idx = idx - CHAN_CNT;
      end
      if (!rr_found && bus.in_valid[idx[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_cand  = idx[SEL_W-1:0];
      end
    end
  end

  // Candidate from the arbitration policy; an out-of-range select yields none.
  always_comb begin
    if (bus.mode) begin
      arb_has  = rr_found;
      arb_cand = rr_cand;
    end else begin
      arb_has  = ({1'b0, bus.sel} < CHAN_CNT);
      arb_cand = bus.sel;
    end
  end

`ifdef MUX_NX1_PKT_LOCK_EN
  // While locked, the packet's channel owns the output regardless of policy.
  always_comb begin
    if (state_reg == LOCK) begin
      has_cand = 1'b1;
      cand     = lock_chan_reg;
    end else begin
      has_cand = arb_has;
      cand     = arb_cand;
    end
  end
`else
  assign has_cand = arb_has;
  assign cand     = arb_cand;
`endif

  // One-hot grant drives both the ready vector and an AND-OR data mux, so
  // no dynamic index ever points past CHANNELS-1.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign grant[gi]       = has_cand && (cand == SEL_W'(gi));
      assign masked_data[gi] = grant[gi] ? bus.in_data[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    cand_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand_data = cand_data | masked_data[k];
    end
  end

  assign cand_last = |(grant & bus.in_last);
  assign accept    = load_en && |(grant & bus.in_valid);
  assign ptr_next  = (cand == LAST_IDX) ? '0 : cand + 1'b1;

  // Reset forces ready low even though the empty output stage would
  // otherwise signal load_en.
  assign bus.in_ready = grant & {CHANNELS{load_en && !rst}};

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= '0;
    end else begin
      if (load_en) begin
        out_valid_reg <= accept;
        if (accept) begin
          out_data_reg <= cand_data;
          out_chan_reg <= cand;
          out_last_reg <= cand_last;
        end
      end
      if (accept && bus.mode) begin
        ptr_reg <= ptr_next;
      end
    end
  end

`ifdef MUX_NX1_PKT_LOCK_EN
  // Packet lock FSM: enter LOCK on a non-last beat, leave on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ARB;
      lock_chan_reg <= '0;
    end else if (accept) begin
      case (state_reg)
        ARB: begin
          if (!cand_last) begin
            state_reg     <= LOCK;
            lock_chan_reg <= cand;
          end
        end
        LOCK: begin
          if (cand_last) begin
            state_reg <= ARB;
          end
        end
        default: state_reg <= ARB;
      endcase
    end
  end
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;
  assign bus.out_last  = out_last_reg;
endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream
// -----------------
// Self-checking bench for mux_nx1_stream. dut_a has 4 channels and carries
// the table-driven vectors, the packet sequence and the mid-packet reset;
// dut_b has 3 channels for the out-of-range select and non-power-of-two wrap.
// Accepted beats are pushed to a scoreboard queue and popped when they
// leave the output register.
module tb_mux_nx1_stream;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux_nx1_stream_if #(.WIDTH(8), .CHANNELS(4)) ifa ();
  mux_nx1_stream_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] chan;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_chan;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] chan, input logic [7:0] data, input logic last);
    beat_t b;
    b.chan = chan;
    b.data = data;
    b.last = last;
    sb.push_back(b);
  endtask

  // Called after inputs settle, away from the edge: a drain happening at the
  // coming edge is compared against the scoreboard, then one cycle passes.
  task automatic tick();
    beat_t b;
    if (ifa.out_valid && ifa.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual chan=%0d data=%02h required=no beat",
                 ifa.out_chan, ifa.out_data);
      end else begin
        b = sb.pop_front();
        $display("beat chan=%0d data=%02h last=%0b", ifa.out_chan, ifa.out_data, ifa.out_last);
        check("sb_chan", 32'(ifa.out_chan), 32'(b.chan));
        check("sb_data", 32'(ifa.out_data), 32'(b.data));
        check("sb_last", 32'(ifa.out_last), 32'(b.last));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] default_data();
    return {8'h13, 8'h12, 8'h11, 8'h10};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g[5];
    int c0_left;
    int c1_left;
    int g;
    logic [7:0] d;
    logic       l;

    // vectors: mode sel valid last ordy | exp_rdy exp_ov exp_chan
    vecs[0]  = '{1'b0, 2'd2, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 2'd2, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[2]  = '{1'b0, 2'd2, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[4]  = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[5]  = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[6]  = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[7]  = '{1'b1, 2'd0, 4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[8]  = '{1'b1, 2'd0, 4'h2, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 2'd0, 4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[10] = '{1'b1, 2'd0, 4'hA, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[11] = '{1'b1, 2'd0, 4'hA, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{1'b1, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 2'd1, 4'h0, 4'hF, 1'b1, 4'b0010, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 2'd0, 4'h1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 2'd1, 4'h3, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[16] = '{1'b0, 2'd1, 4'h3, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[17] = '{1'b0, 2'd1, 4'h3, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0};
    vecs[18] = '{1'b0, 2'd1, 4'h3, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0};

`ifdef MUX_NX1_PKT_LOCK_EN
    exp_g = '{0, 0, 0, 1, 1};
`else
    exp_g = '{0, 1, 0, 1, 0};
`endif

    // Reset with inputs active
    rst           = 1'b1;
    ifa.mode      = 1'b0;
    ifa.sel       = 2'd2;
    ifa.in_data   = default_data();
    ifa.in_valid  = 4'hF;
    ifa.in_last   = 4'hF;
    ifa.out_ready = 1'b1;
    ifb.mode      = 1'b0;
    ifb.sel       = 2'd3;
    ifb.in_data   = {8'h22, 8'h21, 8'h20};
    ifb.in_valid  = 3'b111;
    ifb.in_last   = 3'b111;
    ifb.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(ifa.in_ready),  32'h0);
    check("rst_out_valid", 32'(ifa.out_valid), 32'h0);
    check("rst_out_data",  32'(ifa.out_data),  32'h0);
    check("rst_out_chan",  32'(ifa.out_chan),  32'h0);
    check("rst_out_last",  32'(ifa.out_last),  32'h0);
    rst = 1'b0;

    // Table-driven vectors on dut_a
    for (int i = 0; i < 20; i++) begin
      ifa.mode      = vecs[i].mode;
      ifa.sel       = vecs[i].sel;
      ifa.in_valid  = vecs[i].valid;
      ifa.in_last   = vecs[i].last;
      ifa.out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(ifa.in_ready), 32'(vecs[i].exp_rdy));
      for (int k = 0; k < 4; k++) begin
        if (vecs[i].exp_rdy[k] && vecs[i].valid[k]) begin
          push(2'(k), 8'h10 + 8'(k), vecs[i].last[k]);
        end
      end
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(ifa.out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d_out_chan", i), 32'(ifa.out_chan), 32'(vecs[i].exp_chan));
        check($sformatf("vec%0d_out_data", i), 32'(ifa.out_data), 32'h10 + 32'(vecs[i].exp_chan));
      end
    end

    // Packet sequence: ch0 sends 3 beats (last on the third), ch1 two
    // single-beat packets, round-robin starting from ptr 0.
    c0_left      = 3;
    c1_left      = 2;
    ifa.mode     = 1'b1;
    ifa.out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      ifa.in_valid   = {2'b00, (c1_left > 0), (c0_left > 0)};
      ifa.in_last    = {2'b11, 1'b1, (c0_left == 1)};
      ifa.in_data[7:0]  = 8'h20 + 8'(3 - c0_left);
      ifa.in_data[15:8] = 8'h30 + 8'(2 - c1_left);
      #1;
      g = exp_g[cyc];
      check($sformatf("pkt%0d_in_ready", cyc), 32'(ifa.in_ready), 32'(1) << g);
      if (g == 0) begin
        d = ifa.in_data[7:0];
        l = (c0_left == 1);
        c0_left--;
      end else begin
        d = ifa.in_data[15:8];
        l = 1'b1;
        c1_left--;
      end
      push(2'(g), d, l);
      tick();
    end
    ifa.in_valid = 4'h0;
    ifa.in_data  = default_data();
    tick();

    // Reset in the middle of a packet with the output register full
    ifa.mode      = 1'b1;
    ifa.in_valid  = 4'b0001;
    ifa.in_last   = 4'b0000;
    ifa.out_ready = 1'b1;
    #1;
    check("mid_in_ready", 32'(ifa.in_ready), 32'b0001);
    tick();
    ifa.out_ready = 1'b0;
    #1;
    check("mid_held_valid", 32'(ifa.out_valid), 32'h1);
    check("mid_held_ready", 32'(ifa.in_ready), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(ifa.out_valid), 32'h0);
    check("mid_rst_in_ready",  32'(ifa.in_ready),  32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 4'hF;
    ifa.in_last   = 4'hF;
    #1;
    check("post_rst_ptr0", 32'(ifa.in_ready), 32'b0001);
    push(2'd0, 8'h10, 1'b1);
    tick();
    ifa.in_valid = 4'hE;
    #1;
    check("post_rst_ptr1", 32'(ifa.in_ready), 32'b0010);
    push(2'd1, 8'h11, 1'b1);
    tick();
    ifa.in_valid = 4'h0;
    tick();
    check("sb_empty", 32'(sb.size()), 32'h0);

    // dut_b: out-of-range fixed select gives no grant and no output
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("b_sel3_in_ready%0d", c), 32'(ifb.in_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b_sel3_out_valid%0d", c), 32'(ifb.out_valid), 32'h0);
    end
    ifb.sel = 2'd2;
    #1;
    check("b_sel2_in_ready", 32'(ifb.in_ready), 32'b100);
    @(posedge clk);
    @(negedge clk);
    check("b_sel2_out_valid", 32'(ifb.out_valid), 32'h1);
    check("b_sel2_out_data",  32'(ifb.out_data),  32'h22);
    // dut_b: round-robin wraps 0,1,2,0 with three channels
    ifb.mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("b_rr%0d_in_ready", c), 32'(ifb.in_ready), 32'(1) << (c % 3));
      @(posedge clk);
      @(negedge clk);
      $display("b beat chan=%0d data=%02h", ifb.out_chan, ifb.out_data);
      check($sformatf("b_rr%0d_out_chan", c), 32'(ifb.out_chan), 32'(c % 3));
      check($sformatf("b_rr%0d_out_data", c), 32'(ifb.out_data), 32'h20 + 32'(c % 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
